// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and oversampling helpers for rx and tx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic int mid_tick(input int os);
    return os / 2 - 1;
  endfunction
endpackage

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: synchronizes the serial line and deserializes one frame, pulsing o_done at the stop-bit sample.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_din,
  input  logic                  i_parity_cfg,
  output logic                  o_done,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic [WORD_WIDTH-1:0] o_word
);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] MID  = CW'(mid_tick(OVERSAMPLING));
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);
  uart_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d, vld_q, vld_d;
  logic armed_q, armed_d, par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic line, sample;
  assign line   = sync_q[1];
  assign sample = i_tick && cnt_q == LAST;
  // armed requires a genuinely synchronized high in IDLE, so a line low at reset release or after a bad stop bit is not a start edge
  always_comb begin
    sync_d    = {sync_q[0], i_din};
    vld_d     = {vld_q[0], 1'b1};
    state_d   = state_q;
    cnt_d     = (i_tick && state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld_q[1] && line) armed_d = 1'b1;
        if (armed_q && !line) begin
          state_d  = START;
          cnt_d    = '0;
          armed_d  = 1'b0;
          par_en_d = i_parity_cfg;
        end
      end
      START: if (i_tick && cnt_q == MID) begin
        cnt_d   = '0;
        state_d = line ? IDLE : DATA;
      end
      DATA: if (sample) begin
        cnt_d   = '0;
        shift_d = {line, shift_q[WORD_WIDTH-1:1]};
        bit_d   = bit_q == LAST_BIT ? '0 : bit_q + 1'b1;
        state_d = bit_q != LAST_BIT ? DATA : par_en_q ? PARITY : STOP;
      end
      PARITY: if (sample) begin
        cnt_d     = '0;
        par_bit_d = line;
        state_d   = STOP;
      end
      STOP: if (sample) begin
        cnt_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
        ferr_d  = !line;
        perr_d  = par_en_q && (par_bit_q ^ (^shift_q));
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      vld_q     <= 2'b00;
      armed_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      vld_q     <= vld_d;
      armed_q   <= armed_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end
  assign o_done       = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_word       = shift_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a one-word valid/ready output register and overflow detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUD_RATE    = 115200
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_din,
  input  logic                  i_parity_cfg,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overflow_err
);
  logic done, perr, ferr, load;
  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  uart_rx_deser #(.WORD_WIDTH(WORD_WIDTH), .OVERSAMPLING(OVERSAMPLING)) u_deser (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_din       (i_din),
    .i_parity_cfg(i_parity_cfg),
    .o_done      (done),
    .o_parity_err(perr),
    .o_frame_err (ferr),
    .o_word      (word)
  );
  always_comb begin
    load       = done && (!rd_valid_q || i_rd_ready);
    rd_data_d  = load ? word : rd_data_q;
    rd_valid_d = load ? 1'b1 : (rd_valid_q && i_rd_ready) ? 1'b0 : rd_valid_q;
    ovf_d      = done && rd_valid_q && !i_rd_ready;
    perr_d     = done && perr;
    ferr_d     = done && ferr;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_parity_err   = perr_q;
  assign o_frame_err    = ferr_q;
  assign o_overflow_err = ovf_q;
endmodule
